// File: rtl/instr_mem_responder.sv
// Instruction-fetch memory responder (req/gnt/rvalid): in-order responses RespLatency cycles after accept.
// gnt is combinational and drops on gnt_stall_i or when MaxOutstanding requests are in flight.
package bus_params_pkg;
  localparam int BUS_AW = 32;
  localparam int BUS_DW = 32;
endpackage

module instr_mem_responder #(
  parameter int                   AddrWidth      = bus_params_pkg::BUS_AW,
  parameter int                   DataWidth      = bus_params_pkg::BUS_DW,
  parameter int                   MemWords       = 1024,
  parameter logic [AddrWidth-1:0] BaseAddr       = '0,
  parameter int                   RespLatency    = 1,
  parameter int                   MaxOutstanding = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        instr_req_i,
  input  logic [AddrWidth-1:0]        instr_addr_i,
  output logic                        instr_gnt_o,
  output logic                        instr_rvalid_o,
  output logic [DataWidth-1:0]        instr_rdata_o,
  output logic                        instr_err_o,
  input  logic                        gnt_stall_i,
  input  logic                        mem_we_i,
  input  logic [$clog2(MemWords)-1:0] mem_waddr_i,
  input  logic [DataWidth-1:0]        mem_wdata_i
);

  localparam int                 IW        = $clog2(MemWords);
  localparam int                 CW        = $clog2(MaxOutstanding + 1);
  localparam logic [CW-1:0]      MAX_OUT   = CW'(MaxOutstanding);
  localparam logic [AddrWidth:0] MEM_BYTES = (AddrWidth + 1)'(MemWords * 4);
  localparam logic [IW:0]        MEM_WORDS = (IW + 1)'(MemWords);

  typedef struct packed {
    logic                 vld;
    logic                 err;
    logic [DataWidth-1:0] dat;
  } resp_t;

  logic [DataWidth-1:0] mem_q [MemWords];

  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 accept;
  logic [AddrWidth-1:0] addr_off;
  logic                 dec_err;
  logic [IW-1:0]        rd_idx;
  resp_t                stage0_d;
  resp_t                pipe_q [RespLatency];

  always_comb begin
    instr_gnt_o = instr_req_i & ~gnt_stall_i & (cnt_q < MAX_OUT);
    accept      = instr_req_i & instr_gnt_o;

    // Offset wraps modulo 2^AddrWidth; the explicit below-base test catches the wrap.
    addr_off = instr_addr_i - BaseAddr;
    dec_err  = (instr_addr_i[1:0] != 2'b00)
             | (instr_addr_i < BaseAddr)
             | ({1'b0, addr_off} >= MEM_BYTES);
    rd_idx   = addr_off[IW+1:2];

    stage0_d = '0;
    if (accept) begin
      stage0_d.vld = 1'b1;
      stage0_d.err = dec_err;
      stage0_d.dat = dec_err ? '0 : mem_q[rd_idx];
    end

    // A retiring response frees its slot only at the following edge.
    unique case ({accept, instr_rvalid_o})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      for (int i = 0; i < RespLatency; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      cnt_q     <= cnt_d;
      pipe_q[0] <= stage0_d;
      for (int i = 1; i < RespLatency; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  // Program image storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (mem_we_i && ({1'b0, mem_waddr_i} < MEM_WORDS)) begin
      mem_q[mem_waddr_i] <= mem_wdata_i;
    end
  end

  assign instr_rvalid_o = pipe_q[RespLatency-1].vld;
  assign instr_rdata_o  = pipe_q[RespLatency-1].dat;
  assign instr_err_o    = pipe_q[RespLatency-1].err;

endmodule

// File: tb/tb_instr_mem_responder.sv
// Drives four responder configurations with one shared stimulus stream and
// compares every cycle against a slot-scheduled reference model.
module tb_instr_mem_responder;

  localparam int NI = 4;
  localparam logic [NI-1:0][7:0]  LAT  = {8'd2, 8'd1, 8'd3, 8'd1};
  localparam logic [NI-1:0][7:0]  MAXO = {8'd2, 8'd1, 8'd3, 8'd2};
  localparam logic [NI-1:0][31:0] BASE = {32'h400, 32'h0, 32'h0, 32'h0};
  localparam int MEMB = 4096;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, stall, we;
  logic [31:0] addr, wdata;
  logic [9:0]  waddr;

  logic [NI-1:0]       gnt_w, rvalid_w, err_w;
  logic [NI-1:0][31:0] rdata_w;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    instr_mem_responder #(
      .AddrWidth(32), .DataWidth(32), .MemWords(1024),
      .BaseAddr(BASE[g]), .RespLatency(int'(LAT[g])), .MaxOutstanding(int'(MAXO[g]))
    ) u_dut (
      .clk(clk), .rst_n(rst_n),
      .instr_req_i(req), .instr_addr_i(addr),
      .instr_gnt_o(gnt_w[g]), .instr_rvalid_o(rvalid_w[g]),
      .instr_rdata_o(rdata_w[g]), .instr_err_o(err_w[g]),
      .gnt_stall_i(stall),
      .mem_we_i(we), .mem_waddr_i(waddr), .mem_wdata_i(wdata)
    );
  end

  // Reference: memory image plus a ring of per-cycle expected responses.
  logic [31:0] mem_m   [1024];
  logic        exp_vld [NI][16];
  logic        exp_err [NI][16];
  logic [31:0] exp_dat [NI][16];
  int          inflight [NI];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int k = 0; k < NI; k++) begin
      inflight[k] = 0;
      for (int s = 0; s < 16; s++) begin
        exp_vld[k][s] = 1'b0;
        exp_err[k][s] = 1'b0;
        exp_dat[k][s] = '0;
      end
    end
  endtask

  task automatic step(input logic r, input logic [31:0] a, input logic st,
                      input logic w, input logic [9:0] wa, input logic [31:0] wd);
    @(negedge clk);
    req = r; addr = a; stall = st; we = w; waddr = wa; wdata = wd;
    #1;
    for (int k = 0; k < NI; k++) begin
      int          s, t;
      logic        retire, eg, acc, e;
      logic [31:0] off;
      s = cyc % 16;
      check_eq($sformatf("rvalid[%0d]", k), 32'(rvalid_w[k]), 32'(exp_vld[k][s]));
      check_eq($sformatf("rdata[%0d]", k), rdata_w[k], exp_dat[k][s]);
      check_eq($sformatf("err[%0d]", k), 32'(err_w[k]), 32'(exp_err[k][s]));
      retire = exp_vld[k][s];
      exp_vld[k][s] = 1'b0; exp_err[k][s] = 1'b0; exp_dat[k][s] = '0;
      eg  = r && !st && (inflight[k] < int'(MAXO[k]));
      check_eq($sformatf("gnt[%0d]", k), 32'(gnt_w[k]), 32'(eg));
      acc = r && eg;
      if (acc) begin
        off = a - BASE[k];
        e   = (a[1:0] != 2'b00) || (a < BASE[k]) || (off >= MEMB);
        t   = (cyc + int'(LAT[k])) % 16;
        exp_vld[k][t] = 1'b1;
        exp_err[k][t] = e;
        exp_dat[k][t] = e ? 32'h0 : mem_m[off[11:2]];
      end
      inflight[k] = inflight[k] + (acc ? 1 : 0) - (retire ? 1 : 0);
    end
    if (w) mem_m[wa] = wd;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, 1'b0, 10'h0, 32'h0);
  endtask

  task automatic rd(input logic [31:0] a);
    step(1'b1, a, 1'b0, 1'b0, 10'h0, 32'h0);
  endtask

  // Asynchronous reset asserted mid-cycle; gnt must still follow req with an empty counter.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req = 1'b1; addr = 32'h0; stall = 1'b0; we = 1'b0;
    clear_model();
    #1;
    for (int k = 0; k < NI; k++) begin
      check_eq($sformatf("rst_rvalid[%0d]", k), 32'(rvalid_w[k]), 32'h0);
      check_eq($sformatf("rst_rdata[%0d]", k), rdata_w[k], 32'h0);
      check_eq($sformatf("rst_err[%0d]", k), 32'(err_w[k]), 32'h0);
      check_eq($sformatf("rst_gnt[%0d]", k), 32'(gnt_w[k]), 32'h1);
    end
    @(negedge clk);
    rst_n = 1'b1; req = 1'b0;
    cyc++;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    case ($urandom_range(0, 9))
      0, 1, 2, 3, 4, 5: a = 32'($urandom_range(0, 1535)) << 2;
      6, 7:             a = (32'($urandom_range(0, 1023)) << 2) + 32'($urandom_range(1, 3));
      default: begin
        case ($urandom_range(0, 5))
          0:       a = 32'h0FFC;
          1:       a = 32'h1000;
          2:       a = 32'h03FC;
          3:       a = 32'h0400;
          4:       a = 32'h13FC;
          default: a = 32'h1400;
        endcase
      end
    endcase
    return a;
  endfunction

  initial begin
    rst_n = 1'b0; req = 1'b0; addr = '0; stall = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
    clear_model();
    for (int i = 0; i < 1024; i++) begin
      @(negedge clk);
      we = 1'b1; waddr = 10'(i);
      wdata = (i == 0) ? 32'h0000_0013 : $urandom;
      mem_m[i] = wdata;
    end
    @(negedge clk);
    we = 1'b0; rst_n = 1'b1;

    // Single fetch of the preloaded NOP.
    rd(32'h0);
    idle(1);
    check_eq("nop_rdata", rdata_w[0], 32'h0000_0013);
    idle(3);

    // Back-to-back fetches, then a held request against the single-slot instance.
    rd(32'h0); rd(32'h4); rd(32'h8);
    idle(5);
    rd(32'h0);
    for (int i = 0; i < 6; i++) rd(32'h4);
    idle(5);

    // Misaligned and just-past-end addresses, then in-range with stalls.
    rd(32'h2); rd(32'h1000); rd(32'h3FC); rd(32'h1400);
    idle(5);
    for (int i = 0; i < 3; i++) step(1'b1, 32'h10, 1'b1, 1'b0, 10'h0, 32'h0);
    rd(32'h10);
    idle(5);

    // Reset with responses in flight.
    rd(32'h0); rd(32'h4);
    do_reset();
    idle(2);
    rd(32'h0);
    idle(5);

    // Backdoor write colliding with a read of the same word.
    step(1'b1, 32'h0, 1'b0, 1'b1, 10'h0, 32'hDEAD_BEEF);
    rd(32'h0);
    check_eq("old_data", rdata_w[0], 32'h0000_0013);
    idle(1);
    check_eq("new_data", rdata_w[0], 32'hDEAD_BEEF);
    idle(5);

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 9) < 7, rand_addr(), $urandom_range(0, 4) == 0,
             $urandom_range(0, 9) == 0, 10'($urandom_range(0, 1023)), $urandom);
      end
    end
    idle(6);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
